// File: rtl/echo_indication_output.sv
// echo_indication_output: two independent indication FIFOs (channel 0 = heard,
// channel 1 = heard2) with method-style enable/ready handshakes, a per-method
// message-size lookup and an optional interrupt summary.
// Optional feature macro: ECHO_INDICATION_INTR_EN enables the interrupt outputs;
// without it the interrupt outputs are tied to "no interrupt".
module echo_indication_output #(
  parameter int DEPTH = 2
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] ifc_heard_v,
  input  logic        EN_ifc_heard,
  output logic        RDY_ifc_heard,
  input  logic [15:0] ifc_heard2_a,
  input  logic [15:0] ifc_heard2_b,
  input  logic        EN_ifc_heard2,
  output logic        RDY_ifc_heard2,
  input  logic [15:0] portalIfc_messageSize_size_methodNumber,
  output logic [15:0] portalIfc_messageSize_size,
  output logic [31:0] portalIfc_indications_0_first,
  output logic        RDY_portalIfc_indications_0_first,
  input  logic        EN_portalIfc_indications_0_deq,
  output logic        RDY_portalIfc_indications_0_deq,
  output logic        portalIfc_indications_0_notEmpty,
  output logic [31:0] portalIfc_indications_1_first,
  output logic        RDY_portalIfc_indications_1_first,
  input  logic        EN_portalIfc_indications_1_deq,
  output logic        RDY_portalIfc_indications_1_deq,
  output logic        portalIfc_indications_1_notEmpty,
  output logic        portalIfc_intr_status,
  output logic [31:0] portalIfc_intr_channel
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [1:0][31:0] wr_data;
  logic [1:0][31:0] head;
  logic [1:0]       wr_req;
  logic [1:0]       deq_req;
  logic [1:0]       not_empty;
  logic [1:0]       not_full;

  assign wr_data[0] = ifc_heard_v;
  assign wr_data[1] = {ifc_heard2_a, ifc_heard2_b};
  assign wr_req     = {EN_ifc_heard2, EN_ifc_heard};
  assign deq_req    = {EN_portalIfc_indications_1_deq, EN_portalIfc_indications_0_deq};

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_wr;
    logic          do_rd;

    // A full channel refuses writes even when a deq happens on the same edge.
    assign not_full[ch]  = (count != CNT_FULL);
    assign not_empty[ch] = (count != '0);
    assign do_wr         = wr_req[ch] & not_full[ch];
    assign do_rd         = deq_req[ch] & not_empty[ch];

    // Pointers and occupancy; reset discards everything queued.
    always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + PTR_ONE;
        if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
        if (do_wr && !do_rd)      count <= count + CNT_ONE;
        else if (!do_wr && do_rd) count <= count - CNT_ONE;
      end
    end

    // Word storage is not reset; stale words are unreachable once pointers clear.
    always_ff @(posedge CLK) begin
      if (do_wr) mem[wr_ptr] <= wr_data[ch];
    end

    assign head[ch] = mem[rd_ptr];
  end

  assign RDY_ifc_heard  = not_full[0];
  assign RDY_ifc_heard2 = not_full[1];

  assign portalIfc_indications_0_first     = head[0];
  assign RDY_portalIfc_indications_0_first = not_empty[0];
  assign RDY_portalIfc_indications_0_deq   = not_empty[0];
  assign portalIfc_indications_0_notEmpty  = not_empty[0];

  assign portalIfc_indications_1_first     = head[1];
  assign RDY_portalIfc_indications_1_first = not_empty[1];
  assign RDY_portalIfc_indications_1_deq   = not_empty[1];
  assign portalIfc_indications_1_notEmpty  = not_empty[1];

  // Both methods carry a single 32-bit payload; unknown methods report zero.
  always_comb begin
    portalIfc_messageSize_size = 16'd0;
    if (portalIfc_messageSize_size_methodNumber == 16'd0 ||
        portalIfc_messageSize_size_methodNumber == 16'd1)
      portalIfc_messageSize_size = 16'd32;
  end

`ifdef ECHO_INDICATION_INTR_EN
  // Interrupt summary: any pending word raises status; lowest channel wins.
  always_comb begin
    portalIfc_intr_status  = |not_empty;
    portalIfc_intr_channel = 32'hFFFF_FFFF;
    if (not_empty[0])      portalIfc_intr_channel = 32'd0;
    else if (not_empty[1]) portalIfc_intr_channel = 32'd1;
  end
`else
  assign portalIfc_intr_status  = 1'b0;
  assign portalIfc_intr_channel = 32'hFFFF_FFFF;
`endif

endmodule
